fp_addsub_arbiter: RTL and testbench

//   Shares one adder_subtracter instance among NREQ requesters. Per cycle, it

---
 rtl/fp_addsub_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_fp_addsub_arbiter.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_addsub_arbiter.sv
// fp_addsub_arbiter
// Round-robin front end that shares one in-order FP32 adder/subtracter among
// NREQ clients. Stage p0 arbitrates and sign-adjusts operand B combinationally.
// Stage p1 registers the chosen operation toward the adder. The requester tag
// goes into an in-order FIFO, so each adder result is steered back to the
// client that issued it.
module fp_addsub_arbiter #(
  parameter int NREQ    = 4,
  parameter int MAX_OUT = 4,
  parameter int TAGW    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_vld,
  output logic [NREQ-1:0]      req_rdy,
  input  logic [NREQ*32-1:0]   req_a,
  input  logic [NREQ*32-1:0]   req_b,
  input  logic [NREQ-1:0]      req_sub,
  output logic [NREQ-1:0]      rsp_vld,
  output logic [31:0]          rsp_res,
  output logic                 rsp_ovf,
  output logic [31:0]          add_a,
  output logic [31:0]          add_b,
  output logic                 add_vld,
  input  logic [31:0]          add_res,
  input  logic                 add_res_vld,
  input  logic                 add_ovf,
  output logic                 busy,
  output logic                 err
);

  localparam int DATA_W = 32;
  localparam int CNTW   = $clog2(MAX_OUT + 1);
  localparam int AW     = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

  // First requesting index at or after base, wrapping around; one-hot result.
  function automatic logic [NREQ-1:0] rr_pick(input logic [NREQ-1:0] vld,
                                               input logic [TAGW-1:0] base);
    logic [NREQ-1:0] g;
    logic            found;
    int              j;
    g     = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(base) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!found && vld[j]) begin
        g[j]  = 1'b1;
        found = 1'b1;
      end
    end
    return g;
  endfunction

  // Binary index of a one-hot vector (zero when nothing is set).
  function automatic logic [TAGW-1:0] onehot_idx(input logic [NREQ-1:0] oh);
    logic [TAGW-1:0] idx;
    idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (oh[i]) idx = idx | TAGW'(i);
    end
    return idx;
  endfunction

  // One-hot decode of a requester index.
  function automatic logic [NREQ-1:0] idx_onehot(input logic [TAGW-1:0] idx);
    logic [NREQ-1:0] oh;
    oh = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (int'(idx) == i) oh[i] = 1'b1;
    end
    return oh;
  endfunction

  // Subtraction is addition with B negated: only the sign bit changes, so
  // NaN payloads, infinities and zeros pass through otherwise untouched.
  function automatic logic [DATA_W-1:0] sign_adjust(input logic [DATA_W-1:0] b,
                                                    input logic              sub);
    return sub ? {~b[DATA_W-1], b[DATA_W-2:0]} : b;
  endfunction

  // Round-robin pointer advance with wrap at NREQ (NREQ need not be 2^n).
  function automatic logic [TAGW-1:0] rr_next(input logic [TAGW-1:0] idx);
    return (int'(idx) == NREQ - 1) ? '0 : idx + TAGW'(1);
  endfunction

  // FIFO pointer advance with wrap at MAX_OUT.
  function automatic logic [AW-1:0] fifo_next(input logic [AW-1:0] p);
    return (int'(p) == MAX_OUT - 1) ? '0 : p + AW'(1);
  endfunction

  logic [TAGW-1:0]   ptr;
  logic [CNTW-1:0]   cnt;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [TAGW-1:0]   tag_mem [MAX_OUT];

  logic              credit_p0;
  logic              issue_p0;
  logic              pop_p0;
  logic [TAGW-1:0]   tag_p0;
  logic [TAGW-1:0]   head_p0;
  logic [DATA_W-1:0] a_p0;
  logic [DATA_W-1:0] b_p0;

  // ---- stage p0: arbitration, operand select, return bookkeeping ----
  // Credits come only from the registered count, never from this cycle's
  // returning result, so the grant path stays short.
  assign credit_p0 = (cnt < CNTW'(MAX_OUT));
  assign req_rdy   = credit_p0 ? rr_pick(req_vld, ptr) : '0;
  assign issue_p0  = |req_rdy;
  assign tag_p0    = onehot_idx(req_rdy);
  assign head_p0   = tag_mem[rd_ptr];
  // A result with nothing outstanding is dropped and flagged, never popped.
  assign pop_p0    = add_res_vld && (cnt != '0);
  assign busy      = (cnt != '0);

  // One-hot mux of the granted requester's operands, B sign-adjusted.
  always_comb begin
    a_p0 = '0;
    b_p0 = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_rdy[i]) begin
        a_p0 = req_a[i*DATA_W +: DATA_W];
        b_p0 = sign_adjust(req_b[i*DATA_W +: DATA_W], req_sub[i]);
      end
    end
  end

  // ---- stage p1: registered issue, tag FIFO and response ----
  // Tag storage: only the pointers need reset, the contents are don't-care.
  always_ff @(posedge clk) begin
    if (issue_p0) tag_mem[wr_ptr] <= tag_p0;
  end

  // Arbitration pointer, outstanding count, FIFO pointers and error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr    <= '0;
      cnt    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      err    <= 1'b0;
    end else begin
      if (issue_p0) begin
        ptr    <= rr_next(tag_p0);
        wr_ptr <= fifo_next(wr_ptr);
      end
      if (pop_p0) rd_ptr <= fifo_next(rd_ptr);
      if (issue_p0 && !pop_p0)      cnt <= cnt + CNTW'(1);
      else if (!issue_p0 && pop_p0) cnt <= cnt - CNTW'(1);
      if (add_res_vld && (cnt == '0)) err <= 1'b1;
    end
  end

  // Adder-side issue register: strobe pulses per issue, operands hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      add_vld <= 1'b0;
      add_a   <= '0;
      add_b   <= '0;
    end else begin
      add_vld <= issue_p0;
      if (issue_p0) begin
        add_a <= a_p0;
        add_b <= b_p0;
      end
    end
  end

  // Client-side response register: strobe to the head tag's owner, data holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_vld <= '0;
      rsp_res <= '0;
      rsp_ovf <= 1'b0;
    end else begin
      rsp_vld <= pop_p0 ? idx_onehot(head_p0) : '0;
      if (pop_p0) begin
        rsp_res <= add_res;
        rsp_ovf <= add_ovf;
      end
    end
  end

endmodule

// File: tb/tb_fp_addsub_arbiter.sv
// tb_fp_addsub_arbiter
// Drives the arbiter with client requests and a stub in-order adder. A
// transaction-level reference model predicts grants, the adder-side issue
// and the routed responses.
module tb_fp_addsub_arbiter;

  localparam int NREQ    = 4;
  localparam int MAX_OUT = 4;
  localparam int TAGW    = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req_vld;
  logic [NREQ-1:0]     req_rdy;
  logic [NREQ*32-1:0]  req_a;
  logic [NREQ*32-1:0]  req_b;
  logic [NREQ-1:0]     req_sub;
  logic [NREQ-1:0]     rsp_vld;
  logic [31:0]         rsp_res;
  logic                rsp_ovf;
  logic [31:0]         add_a;
  logic [31:0]         add_b;
  logic                add_vld;
  logic [31:0]         add_res;
  logic                add_res_vld;
  logic                add_ovf;
  logic                busy;
  logic                err;

  always #5 clk = ~clk;

  fp_addsub_arbiter #(.NREQ(NREQ), .MAX_OUT(MAX_OUT), .TAGW(TAGW)) dut (
    .clk(clk), .rst(rst),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_a(req_a), .req_b(req_b),
    .req_sub(req_sub), .rsp_vld(rsp_vld), .rsp_res(rsp_res), .rsp_ovf(rsp_ovf),
    .add_a(add_a), .add_b(add_b), .add_vld(add_vld), .add_res(add_res),
    .add_res_vld(add_res_vld), .add_ovf(add_ovf), .busy(busy), .err(err)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  // Client side: one pending operation per requester.
  logic [31:0] pa [NREQ];
  logic [31:0] pb [NREQ];
  bit          ps [NREQ];
  bit          pend [NREQ];
  bit          auto_repend;

  // Stub adder: in-order queue with per-op latency, optional stall/spurious.
  typedef struct { logic [31:0] res; logic ovf; int ready; } sop_t;
  sop_t sq[$];
  int   stub_credits;
  bit   stub_spurious;
  int   lat_max;

  // Reference model state.
  typedef struct { int tag; logic [31:0] res; logic ovf; } exp_t;
  exp_t            mq[$];
  int              ptr_m, cnt_m;
  bit              err_m;
  logic            e_add_vld, e_rsp_ovf, e_busy, e_err;
  logic [31:0]     e_add_a, e_add_b, e_rsp_res;
  logic [NREQ-1:0] e_rsp_vld;

  int          cyc;
  int          gnt_cnt;
  int          gnt_log[$];
  int          rsp_log[$];
  logic [31:0] last_rsp_res, last_add_b;

  // Stand-in adder arithmetic; only the special cases matter to the tests.
  function automatic logic [31:0] stub_res(input logic [31:0] a, input logic [31:0] b);
    if (a[30:23] == 8'hFF && b[30:23] == 8'hFF && a[22:0] == 0 && b[22:0] == 0 && a[31] != b[31])
      return 32'h7FC00000;
    if (a == 32'h40600000 && b == 32'hC0100000) return 32'h3FA00000;
    return a + b;
  endfunction

  function automatic logic stub_ovf(input logic [31:0] a, input logic [31:0] b);
    return ^(a ^ b);
  endfunction

  function automatic logic [31:0] rand_fp();
    case ($urandom_range(7))
      0:       return 32'h7F800000;
      1:       return 32'hFF800000;
      2:       return 32'h00000000;
      3:       return 32'h80000000;
      4:       return 32'h7FC00000;
      default: return $urandom;
    endcase
  endfunction

  task automatic new_op(input int i);
    pend[i] = 1;
    pa[i]   = rand_fp();
    pb[i]   = rand_fp();
    ps[i]   = ($urandom_range(1) == 1);
  endtask

  // One clock: drive at negedge, check grant at +1, check registers at next negedge.
  task automatic cycle();
    int              eg, act, j;
    logic [NREQ-1:0] eg_oh;
    logic [31:0]     badj;
    bit              popped;
    exp_t            h;
    cyc++;
    for (int i = 0; i < NREQ; i++) begin
      req_vld[i]          = pend[i];
      req_a[i*32 +: 32]   = pa[i];
      req_b[i*32 +: 32]   = pb[i];
      req_sub[i]          = ps[i];
    end
    add_res_vld = 1'b0;
    if (rst) begin
      sq.delete();
    end else if (stub_spurious) begin
      add_res_vld   = 1'b1;
      add_res       = 32'h12345678;
      add_ovf       = 1'b1;
      stub_spurious = 0;
    end else if (sq.size() > 0 && stub_credits != 0) begin
      if (sq[0].ready <= cyc) begin
        add_res_vld = 1'b1;
        add_res     = sq[0].res;
        add_ovf     = sq[0].ovf;
        void'(sq.pop_front());
        if (stub_credits > 0) stub_credits--;
      end
    end
    #1;
    eg = -1;
    if (cnt_m < MAX_OUT) begin
      for (int k = 0; k < NREQ; k++) begin
        j = (ptr_m + k) % NREQ;
        if (eg < 0 && pend[j]) eg = j;
      end
    end
    eg_oh = '0;
    if (eg >= 0) eg_oh[eg] = 1'b1;
    if (!rst) chk("req_rdy", 32'(req_rdy), 32'(eg_oh));
    act = -1;
    for (int i = 0; i < NREQ; i++) if (req_vld[i] && req_rdy[i]) act = i;

    if (rst) begin
      ptr_m = 0; cnt_m = 0; err_m = 0; mq.delete();
      e_add_vld = 0; e_add_a = '0; e_add_b = '0;
      e_rsp_vld = '0; e_rsp_res = '0; e_rsp_ovf = 0;
    end else begin
      popped    = 0;
      e_rsp_vld = '0;
      if (add_res_vld) begin
        if (mq.size() > 0) begin
          h = mq.pop_front();
          e_rsp_vld[h.tag] = 1'b1;
          e_rsp_res = h.res;
          e_rsp_ovf = h.ovf;
          popped    = 1;
        end else begin
          err_m = 1;
        end
      end
      e_add_vld = (eg >= 0);
      if (eg >= 0) begin
        badj    = ps[eg] ? (pb[eg] ^ 32'h80000000) : pb[eg];
        e_add_a = pa[eg];
        e_add_b = badj;
        mq.push_back('{eg, stub_res(pa[eg], badj), stub_ovf(pa[eg], badj)});
        ptr_m = (eg + 1) % NREQ;
        cnt_m++;
      end
      if (popped) cnt_m--;
    end
    e_busy = (cnt_m != 0);
    e_err  = err_m;

    if (!rst && act >= 0) begin
      gnt_log.push_back(act);
      gnt_cnt++;
      pend[act] = 0;
      if (auto_repend) new_op(act);
    end

    @(negedge clk);
    chk("add_vld", 32'(add_vld), 32'(e_add_vld));
    chk("add_a",   add_a,        e_add_a);
    chk("add_b",   add_b,        e_add_b);
    chk("rsp_vld", 32'(rsp_vld), 32'(e_rsp_vld));
    chk("rsp_res", rsp_res,      e_rsp_res);
    chk("rsp_ovf", 32'(rsp_ovf), 32'(e_rsp_ovf));
    chk("busy",    32'(busy),    32'(e_busy));
    chk("err",     32'(err),     32'(e_err));
    for (int i = 0; i < NREQ; i++) begin
      if (rsp_vld[i]) begin
        rsp_log.push_back(i);
        last_rsp_res = rsp_res;
      end
    end
    if (add_vld) begin
      last_add_b = add_b;
      sq.push_back('{stub_res(add_a, add_b), stub_ovf(add_a, add_b),
                     cyc + 2 + int'($urandom_range(lat_max))});
    end
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic reset_dut();
    for (int i = 0; i < NREQ; i++) pend[i] = 0;
    stub_credits = -1;
    auto_repend  = 0;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    gnt_log.delete();
    rsp_log.delete();
    gnt_cnt = 0;
  endtask

  task automatic wait_rsp(input string tag, input int n);
    int k;
    k = 0;
    while (rsp_log.size() < n && k < 60) begin
      cycle();
      k++;
    end
    chk(tag, 32'(rsp_log.size()), 32'(n));
  endtask

  task automatic drain_and_compare(input string tag);
    int k, diff;
    for (int i = 0; i < NREQ; i++) pend[i] = 0;
    stub_credits = -1;
    k = 0;
    while (cnt_m != 0 && k < 80) begin
      cycle();
      k++;
    end
    run(4);
    chk({tag, "_count"}, 32'(rsp_log.size()), 32'(gnt_log.size()));
    diff = 0;
    for (int i = 0; i < gnt_log.size() && i < rsp_log.size(); i++)
      if (gnt_log[i] != rsp_log[i]) diff++;
    chk({tag, "_order"}, 32'(diff), 32'(0));
  endtask

  initial begin
    rst = 1'b1; req_vld = '0; req_a = '0; req_b = '0; req_sub = '0;
    add_res = '0; add_res_vld = 1'b0; add_ovf = 1'b0;
    for (int i = 0; i < NREQ; i++) begin pa[i] = '0; pb[i] = '0; ps[i] = 0; pend[i] = 0; end
    auto_repend = 0; stub_credits = -1; stub_spurious = 0; lat_max = 2;
    ptr_m = 0; cnt_m = 0; err_m = 0; cyc = 0; gnt_cnt = 0;
    last_rsp_res = '0; last_add_b = '0;

    // Reset state
    reset_dut();
    reset_dut();
    chk("rst_rdy", 32'(req_rdy), 32'(0));

    // Single subtract from requester 0: 3.5 - 2.25
    pend[0] = 1; pa[0] = 32'h40600000; pb[0] = 32'h40100000; ps[0] = 1;
    wait_rsp("t1_wait", 1);
    chk("t1_add_b", last_add_b, 32'hC0100000);
    chk("t1_res", last_rsp_res, 32'h3FA00000);
    if (rsp_log.size() > 0) chk("t1_tag", 32'(rsp_log[0]), 32'(0));

    // All four requesting from ptr=0 with the adder stalled
    reset_dut();
    stub_credits = 0;
    for (int i = 0; i < NREQ; i++) new_op(i);
    run(8);
    chk("t2_ngnt", 32'(gnt_log.size()), 32'(4));
    for (int i = 0; i < gnt_log.size() && i < 4; i++) chk("t2_gnt_order", 32'(gnt_log[i]), 32'(i));
    stub_credits = -1;
    wait_rsp("t2_wait", 4);
    run(5);
    chk("t2_nrsp", 32'(rsp_log.size()), 32'(4));
    for (int i = 0; i < rsp_log.size() && i < 4; i++) chk("t2_rsp_order", 32'(rsp_log[i]), 32'(i));

    // Credit limit, then a single return frees exactly one credit
    reset_dut();
    stub_credits = 0;
    auto_repend  = 1;
    for (int i = 0; i < NREQ; i++) new_op(i);
    run(10);
    chk("t3_gnt_at_limit", 32'(gnt_cnt), 32'(4));
    chk("t3_rdy_stall", 32'(req_rdy), 32'(0));
    gnt_cnt = 0;
    stub_credits = 1;
    run(8);
    chk("t3_one_more", 32'(gnt_cnt), 32'(1));

    // Issue and return in the same cycle at cnt = MAX_OUT-1
    auto_repend = 0;
    for (int i = 0; i < NREQ; i++) pend[i] = 0;
    stub_credits = 1;
    run(5);
    chk("t4_busy", 32'(busy), 32'(1));
    gnt_cnt = 0;
    stub_credits = 1;
    new_op(2);
    cycle();
    new_op(0);
    new_op(1);
    run(4);
    chk("t4_gnts", 32'(gnt_cnt), 32'(2));
    drain_and_compare("t4_fifo");

    // Reset with three in flight
    reset_dut();
    stub_credits = 0;
    for (int i = 0; i < 3; i++) new_op(i);
    run(4);
    chk("t5_pre_busy", 32'(busy), 32'(1));
    for (int i = 0; i < NREQ; i++) pend[i] = 0;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("t5_busy", 32'(busy), 32'(0));
    chk("t5_rsp_vld", 32'(rsp_vld), 32'(0));
    gnt_log.delete();
    rsp_log.delete();
    stub_credits = -1;
    for (int i = 0; i < NREQ; i++) new_op(i);
    cycle();
    chk("t5_first_gnt", (gnt_log.size() > 0) ? 32'(gnt_log[0]) : 32'hFFFFFFFF, 32'(0));
    drain_and_compare("t5_after");

    // Spurious result with nothing outstanding, then Inf - Inf
    reset_dut();
    stub_spurious = 1;
    cycle();
    chk("t6_err", 32'(err), 32'(1));
    chk("t6_rsp_vld", 32'(rsp_vld), 32'(0));
    pend[1] = 1; pa[1] = 32'h7F800000; pb[1] = 32'h7F800000; ps[1] = 1;
    wait_rsp("t6_wait", 1);
    chk("t6_add_b", last_add_b, 32'hFF800000);
    chk("t6_nan", 32'(last_rsp_res[30:23] == 8'hFF && last_rsp_res[22:0] != 0), 32'(1));
    if (rsp_log.size() > 0) chk("t6_tag", 32'(rsp_log[0]), 32'(1));
    chk("t6_err_sticky", 32'(err), 32'(1));

    // Random traffic with occasional adder stalls
    reset_dut();
    for (int c = 0; c < 1500; c++) begin
      lat_max = int'($urandom_range(3));
      for (int i = 0; i < NREQ; i++) if (!pend[i] && $urandom_range(99) < 40) new_op(i);
      if ($urandom_range(99) < 4) stub_credits = (stub_credits == 0) ? -1 : 0;
      cycle();
    end
    drain_and_compare("rand");
    chk("rand_err", 32'(err), 32'(0));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
